argmax_seq: RTL and testbench
=============================

// Module: argmax_seq
// PURPOSE
// - Serial counterpart of the combinational argmax: consumes a stream of 2**S
//   M-bit elements, one per accepted beat, and returns max value and index.
// - Sits between a streaming element source and any consumer of (max, ind);
//   trades area for latency of 2**S beats. Valid/ready on both sides.
// PARAMETERS
// - S  5  log2 of elements per frame (frame length N = 2**S)
// - M  8  element width in bits
// PORTS
// - clk        in   1    clock, all state updates on rising edge
// - rst        in   1    synchronous, active-high reset
// - in_data    in   M    element value
// - in_valid   in   1    in_data valid
// - in_ready   out  1    block accepts element this cycle
// - max        out  M    frame maximum, stable while out_valid
// - ind        out  S    index (0..N-1, arrival order) of max
// - out_valid  out  1    result available
// - out_ready  in   1    consumer takes result
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE, cnt=0, max=0, ind=0, out_valid=0.
//   Reset mid-frame discards partial frame; no result emitted for it.
// - Accept beat: in_valid & in_ready at rising edge. Result handoff:
//   out_valid & out_ready at rising edge.
// - States: IDLE (in_ready=1, cnt=0), ACC (in_ready=1), DONE (in_ready=0,
//   out_valid=1). in_ready is purely a function of state.
// - IDLE: on accept, max<=in_data, ind<=0, cnt<=1, ->ACC (if S=0 -> DONE).
// - ACC: on accept, if in_data > max then max<=in_data, ind<=cnt.
//   cnt<=cnt+1; on accept with cnt==N-1 -> DONE (cnt wraps to 0).
//   No accept: hold everything (bubbles allowed, any length).
// - DONE: hold max/ind/out_valid until handoff; then ->IDLE, out_valid<=0.
//   Next frame's first element accepted no earlier than cycle after handoff.
// - Ties: strict greater-than; lowest index wins among equal maxima.
// - Latency: out_valid rises the cycle after the N-th accepted beat.
//   Throughput: one frame per N+1 cycles minimum (N beats + 1 DONE cycle).
// - cnt is S+1 bits internally or S bits with explicit terminal compare;
//   ind is S bits, never exceeds N-1.
// - in_data ignored when in_valid=0; out_ready ignored when out_valid=0.
// CONFIGURATION
// - SIGNED_CMP_EN defined: elements and max compared as two's-complement
//   signed M-bit values (e.g. M=8: 8'h80=-128 is smallest).
// - SIGNED_CMP_EN undefined (default): unsigned comparison.
// - Only the comparator changes; state machine, ports and timing identical.
// TESTING
// - S=2,M=8, back-to-back frame {3,9,2,7}, out_ready=1 -> max=9, ind=1,
//   out_valid high exactly one cycle, 1 cycle after 4th beat.
// - Ties {5,5,1,5} -> max=5, ind=0; all-zero frame -> max=0, ind=0.
// - Random in_valid bubbles and out_ready held low 10 cycles after DONE ->
//   in_ready=0 throughout DONE, max/ind stable, result unchanged on release.
// - rst asserted after 2 of 4 beats, then frame {1,4,8,6} -> only one result,
//   max=8, ind=2; all outputs 0 in cycle after rst.
// - Unsigned build {8'h80,8'h7F,8'h01,8'hFF} -> max=8'hFF, ind=3;
//   SIGNED_CMP_EN build same frame -> max=8'h7F, ind=1.
// - Default S=5,M=8, 100 frames of $urandom%100 vs software model -> all match.

Source files
------------

// File: rtl/argmax_seq.sv
// ============================================================================
// Module   : argmax_seq
// Purpose  : Streaming argmax. Consumes one frame of 2**S elements over
//            valid/ready and reports the frame maximum and its arrival index.
//            Optional macro SIGNED_CMP_EN selects a two's-complement compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_seq #(
  parameter int S = 5,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [M-1:0] max,
  output logic [S-1:0] ind,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N = 1 << S;
  localparam logic [S-1:0] LAST = S'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [S-1:0] cnt_q;
  logic [M-1:0] max_q;
  logic [S-1:0] ind_q;
  logic         out_valid_q;
  logic         elem_gt;

  // Strict greater-than, so the earliest of several equal maxima is kept.
`ifdef SIGNED_CMP_EN
  assign elem_gt = $signed(in_data) > $signed(max_q);
`else
  assign elem_gt = in_data > max_q;
`endif

  assign in_ready  = (state_q != DONE);
  assign max       = max_q;
  assign ind       = ind_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      ind_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            max_q <= in_data;
            ind_q <= '0;
            if (N == 1) begin
              cnt_q       <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q   <= S'(1);
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            if (elem_gt) begin
              max_q <= in_data;
              ind_q <= cnt_q;
            end
            // Counter wraps to zero on the last beat of the frame.
            cnt_q <= cnt_q + S'(1);
            if (cnt_q == LAST) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_argmax_seq.sv
// ============================================================================
// Module   : tb_argmax_seq
// Purpose  : Directed and model-checked bench for argmax_seq (S=2 and S=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argmax_seq;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_valid5;
  logic       out_ready;

  logic       in_ready;
  logic [7:0] max_o;
  logic [1:0] ind_o;
  logic       out_valid;

  logic       in_ready5;
  logic [7:0] max5;
  logic [4:0] ind5;
  logic       out_valid5;

  int n_checks;
  int n_fail;

  argmax_seq #(.S(2), .M(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .max       (max_o),
    .ind       (ind_o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  argmax_seq #(.S(5), .M(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .max       (max5),
    .ind       (ind5),
    .out_valid (out_valid5),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Present one element to the S=2 instance and return at the negedge after it is taken.
  task automatic beat(input logic [7:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic beat5(input logic [7:0] v);
    int n;
    n = 0;
    in_data   = v;
    in_valid5 = 1'b1;
    while (in_ready5 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL beat5_timeout: in_ready=%b required 1", in_ready5);
    end
    @(negedge clk);
    in_valid5 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    n_checks++; if (max_o !== 8'd0) begin n_fail++; $display("FAIL reset_max: got %0d want 0", max_o); end
    n_checks++; if (ind_o !== 2'd0) begin n_fail++; $display("FAIL reset_ind: got %0d want 0", ind_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid5 !== 1'b0 || max5 !== 8'd0 || ind5 !== 5'd0) begin
      n_fail++; $display("FAIL reset_dut5: ov=%b max=%0d ind=%0d want 0/0/0", out_valid5, max5, ind5);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    beat(8'd3); beat(8'd9); beat(8'd2);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_ov: got %b want 0", out_valid); end
    beat(8'd7);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ov: got %b want 1", out_valid); end
    n_checks++; if (max_o !== 8'd9) begin n_fail++; $display("FAIL b2b_max: got %0d want 9", max_o); end
    n_checks++; if (ind_o !== 2'd1) begin n_fail++; $display("FAIL b2b_ind: got %0d want 1", ind_o); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_one_cycle: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready); end

    beat(8'd5); beat(8'd5); beat(8'd1); beat(8'd5);
    n_checks++; if (out_valid !== 1'b1 || max_o !== 8'd5 || ind_o !== 2'd0) begin
      n_fail++; $display("FAIL tie: ov=%b max=%0d ind=%0d want 1/5/0", out_valid, max_o, ind_o);
    end
    @(negedge clk);

    beat(8'd0); beat(8'd0); beat(8'd0); beat(8'd0);
    n_checks++; if (out_valid !== 1'b1 || max_o !== 8'd0 || ind_o !== 2'd0) begin
      n_fail++; $display("FAIL zeros: ov=%b max=%0d ind=%0d want 1/0/0", out_valid, max_o, ind_o);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic [7:0] vals [4];
    vals = '{8'd10, 8'd200, 8'd200, 8'd50};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(vals[i]);
      if (i < 3) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_ov: got %b want 0", out_valid); end
        end
      end
    end
    n_checks++; if (out_valid !== 1'b1 || max_o !== 8'd200 || ind_o !== 2'd1) begin
      n_fail++; $display("FAIL stall_result: ov=%b max=%0d ind=%0d want 1/200/1", out_valid, max_o, ind_o);
    end
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || max_o !== 8'd200 || ind_o !== 2'd1) begin
        n_fail++; $display("FAIL stall_hold c=%0d: rdy=%b ov=%b max=%0d ind=%0d want 0/1/200/1", c, in_ready, out_valid, max_o, ind_o);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midframe;
    out_ready = 1'b1;
    beat(8'd100); beat(8'd150);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || max_o !== 8'd0 || ind_o !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_outputs: ov=%b max=%0d ind=%0d rdy=%b want 0/0/0/1", out_valid, max_o, ind_o, in_ready);
    end
    beat(8'd1); beat(8'd4); beat(8'd8);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early_ov: got %b want 0", out_valid); end
    beat(8'd6);
    n_checks++; if (out_valid !== 1'b1 || max_o !== 8'd8 || ind_o !== 2'd2) begin
      n_fail++; $display("FAIL midrst_result: ov=%b max=%0d ind=%0d want 1/8/2", out_valid, max_o, ind_o);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_single: got %b want 0", out_valid); end
  endtask

  task automatic test_signedness;
    logic [7:0] exp_max;
    logic [1:0] exp_ind;
`ifdef SIGNED_CMP_EN
    exp_max = 8'h7F; exp_ind = 2'd1;
`else
    exp_max = 8'hFF; exp_ind = 2'd3;
`endif
    out_ready = 1'b1;
    beat(8'h80); beat(8'h7F); beat(8'h01); beat(8'hFF);
    n_checks++; if (out_valid !== 1'b1 || max_o !== exp_max || ind_o !== exp_ind) begin
      n_fail++; $display("FAIL cmp_mode: ov=%b max=%h ind=%0d want 1/%h/%0d", out_valid, max_o, ind_o, exp_max, exp_ind);
    end
    @(negedge clk);
  endtask

  task automatic test_random_frames;
    logic [7:0] v;
    logic [7:0] m_max;
    logic [4:0] m_ind;
    out_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      m_max = 8'd0;
      m_ind = 5'd0;
      for (int i = 0; i < 32; i++) begin
        v = 8'($urandom % 100);
        if (i == 0 || v > m_max) begin
          m_max = v;
          m_ind = 5'(i);
        end
        beat5(v);
        if (i < 31 && ($urandom % 4) == 0) @(negedge clk);
      end
      n_checks++; if (out_valid5 !== 1'b1 || max5 !== m_max || ind5 !== m_ind) begin
        n_fail++; $display("FAIL random_frame %0d: ov=%b max=%0d ind=%0d want 1/%0d/%0d", f, out_valid5, max5, ind5, m_max, m_ind);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    in_valid5 = 1'b0;
    out_ready = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_stall;
    test_reset_midframe;
    test_signedness;
    test_random_frames;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
